// File: rtl/avalon_axi_lite_arbiter.sv
// Two-port round-robin arbiter in front of one Avalon-to-AXI4-Lite bridge.
// One command in flight at a time; a watchdog parks the block in ERR if the bridge hangs.
module avalon_axi_lite_arbiter #(
    parameter int unsigned C_TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] C_ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESET,
    input  logic        s0_avalonRead,
    input  logic        s0_avalonWrite,
    input  logic [31:0] s0_avalonAddr,
    input  logic [3:0]  s0_avalonBE,
    input  logic [31:0] s0_avalonWriteData,
    output logic        s0_avalonWaitReq,
    output logic        s0_avalonReadValid,
    output logic [31:0] s0_avalonReadData,
    input  logic        s1_avalonRead,
    input  logic        s1_avalonWrite,
    input  logic [31:0] s1_avalonAddr,
    input  logic [3:0]  s1_avalonBE,
    input  logic [31:0] s1_avalonWriteData,
    output logic        s1_avalonWaitReq,
    output logic        s1_avalonReadValid,
    output logic [31:0] s1_avalonReadData,
    output logic        avalonRead,
    output logic        avalonWrite,
    output logic [31:0] avalonAddr,
    output logic [31:0] avalonWriteData,
    output logic [3:0]  avalonBE,
    input  logic        avalonWaitReq,
    input  logic        avalonReadValid,
    input  logic [31:0] avalonReadData,
    output logic [1:0]  grant,
    output logic        timeoutErr,
    input  logic        timeoutClr
);
    // state | meaning
    // IDLE  | no owner, arbitrate incoming requests
    // BUSY  | granted command forwarded, waiting for accept / read data
    // GAP   | one-cycle bridge rest after completion, arbitrate again
    // ERR   | bridge hung; requests complete locally with error data
    typedef enum logic [1:0] {IDLE, BUSY, GAP, ERR} state_t;

    localparam int CW = $clog2(C_TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT_CYCLES - 1);

    state_t        state, state_next;
    logic [1:0]    grant_q;
    logic          last_grant;
    logic          timeout_err;
    logic [31:0]   rd_data_reg;
    logic          accepted;
    logic          rv_seen;
    logic [CW-1:0] counter;

    logic [1:0] req_w, req_r, req;
    logic       any_req, pick;
    logic       busy, sel, sel_w, sel_r;
    logic       cmd_w, cmd_r, acc_now, rv_now;
    logic       done, timeout, finish;

    assign req_w   = {s1_avalonWrite, s0_avalonWrite};
    assign req_r   = {s1_avalonRead & ~s1_avalonWrite, s0_avalonRead & ~s0_avalonWrite};
    assign req     = req_w | req_r;
    assign any_req = |req;
    assign pick    = (req[0] & req[1]) ? ~last_grant : req[1];

    assign busy    = (state == BUSY);
    assign sel     = grant_q[1];
    assign sel_w   = req_w[sel];
    assign sel_r   = req_r[sel];
    assign cmd_w   = busy & sel_w & ~accepted;
    assign cmd_r   = busy & sel_r & ~accepted;
    assign acc_now = (cmd_w | cmd_r) & ~avalonWaitReq;
    assign rv_now  = busy & avalonReadValid;
    // A read needs both acceptance and data, which may arrive in either order.
    assign done    = busy & (sel_w ? acc_now
                                   : ((accepted | acc_now) & (rv_seen | avalonReadValid)));
    assign timeout = busy & ~done & (counter == CNT_LAST);
    assign finish  = done | timeout;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) state <= IDLE;
        else              state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, GAP: state_next = any_req ? BUSY : IDLE;
            BUSY: begin
                if (done)         state_next = GAP;
                else if (timeout) state_next = ERR;
            end
            ERR:       if (timeoutClr) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            grant_q     <= 2'b00;
            last_grant  <= 1'b1;
            timeout_err <= 1'b0;
            rd_data_reg <= '0;
            accepted    <= 1'b0;
            rv_seen     <= 1'b0;
            counter     <= '0;
        end else begin
            if ((state == IDLE || state == GAP) && any_req) begin
                grant_q    <= pick ? 2'b10 : 2'b01;
                last_grant <= pick;
            end else if (finish) begin
                grant_q    <= 2'b00;
            end
            if (finish) begin
                accepted <= 1'b0;
                rv_seen  <= 1'b0;
                counter  <= '0;
            end else if (busy) begin
                if (acc_now)          accepted <= 1'b1;
                if (rv_now)           rv_seen  <= 1'b1;
                if (counter != '1)    counter  <= counter + CW'(1);
            end
            if (rv_now) rd_data_reg <= avalonReadData;
            if (timeout)         timeout_err <= 1'b1;
            else if (timeoutClr) timeout_err <= 1'b0;
        end
    end

    logic [1:0]  wait_o, rv_o;
    logic [31:0] rd_o [2];

    always_comb begin
        avalonWrite     = cmd_w;
        avalonRead      = cmd_r;
        avalonAddr      = '0;
        avalonWriteData = '0;
        avalonBE        = '0;
        if (busy) begin
            avalonAddr      = sel ? s1_avalonAddr      : s0_avalonAddr;
            avalonWriteData = sel ? s1_avalonWriteData : s0_avalonWriteData;
            avalonBE        = sel ? s1_avalonBE        : s0_avalonBE;
        end
        for (int i = 0; i < 2; i++) begin
            wait_o[i] = req[i];
            rv_o[i]   = 1'b0;
            rd_o[i]   = '0;
            if (state == ERR) begin
                wait_o[i] = 1'b0;
                rv_o[i]   = req_r[i];
                rd_o[i]   = req_r[i] ? C_ERR_DATA : '0;
            end else if (finish && grant_q[i]) begin
                wait_o[i] = 1'b0;
                rv_o[i]   = req_r[i];
                if (req_r[i])
                    rd_o[i] = timeout ? C_ERR_DATA
                                      : (avalonReadValid ? avalonReadData : rd_data_reg);
            end
        end
    end

    assign s0_avalonWaitReq   = wait_o[0];
    assign s0_avalonReadValid = rv_o[0];
    assign s0_avalonReadData  = rd_o[0];
    assign s1_avalonWaitReq   = wait_o[1];
    assign s1_avalonReadValid = rv_o[1];
    assign s1_avalonReadData  = rd_o[1];
    assign grant              = grant_q;
    assign timeoutErr         = timeout_err;

endmodule

// File: tb/tb_avalon_axi_lite_arbiter.sv
// Bench for avalon_axi_lite_arbiter: directed scenarios with a per-port read-data scoreboard.
module tb_avalon_axi_lite_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s0_rd, s0_wr, s1_rd, s1_wr;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic [3:0]  s0_be, s1_be;
    logic        s0_wait, s0_rv, s1_wait, s1_rv;
    logic [31:0] s0_rdata, s1_rdata;
    logic        b_rd, b_wr, b_wait, b_rv;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;
    logic [1:0]  grant;
    logic        terr, tclr;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] e0, e1;

    avalon_axi_lite_arbiter #(.C_TIMEOUT_CYCLES(TO), .C_ERR_DATA(32'hDEADBEEF)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .s0_avalonRead(s0_rd), .s0_avalonWrite(s0_wr), .s0_avalonAddr(s0_addr),
        .s0_avalonBE(s0_be), .s0_avalonWriteData(s0_wdata), .s0_avalonWaitReq(s0_wait),
        .s0_avalonReadValid(s0_rv), .s0_avalonReadData(s0_rdata),
        .s1_avalonRead(s1_rd), .s1_avalonWrite(s1_wr), .s1_avalonAddr(s1_addr),
        .s1_avalonBE(s1_be), .s1_avalonWriteData(s1_wdata), .s1_avalonWaitReq(s1_wait),
        .s1_avalonReadValid(s1_rv), .s1_avalonReadData(s1_rdata),
        .avalonRead(b_rd), .avalonWrite(b_wr), .avalonAddr(b_addr),
        .avalonWriteData(b_wdata), .avalonBE(b_be), .avalonWaitReq(b_wait),
        .avalonReadValid(b_rv), .avalonReadData(b_rdata),
        .grant(grant), .timeoutErr(terr), .timeoutClr(tclr)
    );

    // Scoreboard: every readValid pulse must match the oldest expected word for that port.
    always @(negedge clk) begin
        if (s0_rv === 1'b1) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL s0_readvalid_unexpected: got data %h, expected no readValid", s0_rdata);
            end else begin
                e0 = exp_q0.pop_front();
                if (s0_rdata !== e0) begin
                    errors++;
                    $display("FAIL s0_readdata: got %h expected %h", s0_rdata, e0);
                end
            end
        end
        if (s1_rv === 1'b1) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL s1_readvalid_unexpected: got data %h, expected no readValid", s1_rdata);
            end else begin
                e1 = exp_q1.pop_front();
                if (s1_rdata !== e1) begin
                    errors++;
                    $display("FAIL s1_readdata: got %h expected %h", s1_rdata, e1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s0_rd = 0; s0_wr = 0; s0_addr = '0; s0_wdata = '0; s0_be = '0;
        s1_rd = 0; s1_wr = 0; s1_addr = '0; s1_wdata = '0; s1_be = '0;
        b_wait = 1; b_rv = 0; b_rdata = '0; tclr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        s0_rd = 1;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (b_rd !== 1'b0 || b_wr !== 1'b0) begin errors++; $display("FAIL reset_cmd: got rd=%b wr=%b expected 0 0", b_rd, b_wr); end
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", terr); end
        checks++; if (s0_wait !== 1'b1) begin errors++; $display("FAIL reset_s0_wait: got %b expected 1", s0_wait); end
        checks++; if (s1_wait !== 1'b0) begin errors++; $display("FAIL reset_s1_wait: got %b expected 0", s1_wait); end
        checks++; if (s0_rdata !== 32'h0 || s1_rv !== 1'b0) begin errors++; $display("FAIL reset_rdata: got %h rv1=%b expected 0 0", s0_rdata, s1_rv); end
        s0_rd = 0;
        do_reset();
    endtask

    task automatic test_write();
        do_reset();
        s0_wr = 1; s0_addr = 32'h40; s0_wdata = 32'h12345678; s0_be = 4'hF; b_wait = 1;
        @(negedge clk);
        checks++; if (b_wr !== 1'b0 || s0_wait !== 1'b1) begin errors++; $display("FAIL wr_c0: got wr=%b wait=%b expected 0 1", b_wr, s0_wait); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            b_wait = (c == 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++; if (b_wr !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL wr_cmd c%0d: got wr=%b grant=%b expected 1 01", c, b_wr, grant); end
            checks++; if (s0_wait !== (c != 4)) begin errors++; $display("FAIL wr_wait c%0d: got %b expected %b", c, s0_wait, (c != 4)); end
            checks++; if (b_addr !== 32'h40 || b_wdata !== 32'h12345678 || b_be !== 4'hF) begin errors++; $display("FAIL wr_fields c%0d: got %h %h %h expected 40 12345678 f", c, b_addr, b_wdata, b_be); end
        end
        tick();
        s0_wr = 0; b_wait = 1;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || b_wr !== 1'b0) begin errors++; $display("FAIL wr_gap: got grant=%b wr=%b expected 00 0", grant, b_wr); end
    endtask

    task automatic test_both_read();
        do_reset();
        s0_rd = 1; s0_addr = 32'h100; s1_rd = 1; s1_addr = 32'h200; b_wait = 1;
        exp_q0.push_back(32'hA5A5A5A5);
        exp_q1.push_back(32'h5A5A5A5A);
        tick();
        b_wait = 0;
        @(negedge clk);
        checks++; if (grant !== 2'b01 || b_rd !== 1'b1 || b_addr !== 32'h100) begin errors++; $display("FAIL rr_first: got grant=%b rd=%b addr=%h expected 01 1 100", grant, b_rd, b_addr); end
        checks++; if (s1_wait !== 1'b1) begin errors++; $display("FAIL rr_s1_stall: got %b expected 1", s1_wait); end
        tick();
        b_wait = 1; b_rv = 1; b_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        checks++; if (b_rd !== 1'b0 || s0_wait !== 1'b0 || s0_rv !== 1'b1) begin errors++; $display("FAIL rr_s0_done: got rd=%b wait=%b rv=%b expected 0 0 1", b_rd, s0_wait, s0_rv); end
        checks++; if (s1_rv !== 1'b0 || s1_rdata !== 32'h0) begin errors++; $display("FAIL rr_s1_quiet: got rv=%b data=%h expected 0 0", s1_rv, s1_rdata); end
        tick();
        s0_rd = 0; b_rv = 0;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || b_rd !== 1'b0) begin errors++; $display("FAIL rr_gap: got grant=%b rd=%b expected 00 0", grant, b_rd); end
        tick();
        b_wait = 0; b_rv = 1; b_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        checks++; if (grant !== 2'b10 || b_addr !== 32'h200 || s1_rv !== 1'b1 || s0_rv !== 1'b0) begin errors++; $display("FAIL rr_second: got grant=%b addr=%h rv1=%b rv0=%b expected 10 200 1 0", grant, b_addr, s1_rv, s0_rv); end
        tick();
        s1_rd = 0; b_rv = 0; b_wait = 1;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || s1_rv !== 1'b0) begin errors++; $display("FAIL rr_end: got grant=%b rv1=%b expected 00 0", grant, s1_rv); end
    endtask

    task automatic test_read_early();
        do_reset();
        s0_rd = 1; s0_addr = 32'h300; b_wait = 1;
        exp_q0.push_back(32'hCAFEF00D);
        tick();
        b_rv = 1; b_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (b_rd !== 1'b1 || s0_wait !== 1'b1 || s0_rv !== 1'b0) begin errors++; $display("FAIL early_rv: got rd=%b wait=%b rv=%b expected 1 1 0", b_rd, s0_wait, s0_rv); end
        tick();
        b_rv = 0; b_rdata = 32'h11111111; b_wait = 0;
        @(negedge clk);
        checks++; if (s0_wait !== 1'b0 || s0_rv !== 1'b1) begin errors++; $display("FAIL early_done: got wait=%b rv=%b expected 0 1", s0_wait, s0_rv); end
        tick();
        s0_rd = 0; b_wait = 1;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL early_gap: got grant=%b expected 00", grant); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] expg;
        int n;
        do_reset();
        b_wait = 0;
        s0_wr = 1; s0_addr = 32'h1000; s0_wdata = 32'h1;
        s1_wr = 1; s1_addr = 32'h2000; s1_wdata = 32'h2;
        expg = 2'b01;
        n = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            @(negedge clk);
            if (grant !== 2'b00) begin
                checks++;
                if (grant !== expg || b_wr !== 1'b1 || b_addr !== ((expg == 2'b01) ? 32'h1000 : 32'h2000)) begin
                    errors++;
                    $display("FAIL b2b_grant c%0d: got grant=%b wr=%b addr=%h expected grant=%b", c, grant, b_wr, b_addr, expg);
                end
                expg = ~expg;
                n++;
            end
        end
        checks++; if (n !== 6) begin errors++; $display("FAIL b2b_count: got %0d grants expected 6", n); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        s0_rd = 1; s0_addr = 32'h400; b_wait = 1;
        exp_q0.push_back(32'hDEADBEEF);
        for (int c = 1; c <= TO; c++) begin
            tick();
            @(negedge clk);
            checks++; if (terr !== 1'b0 || b_rd !== 1'b1) begin errors++; $display("FAIL to_busy c%0d: got terr=%b rd=%b expected 0 1", c, terr, b_rd); end
            checks++; if (s0_wait !== (c != TO) || s0_rv !== (c == TO)) begin errors++; $display("FAIL to_wait c%0d: got wait=%b rv=%b expected %b %b", c, s0_wait, s0_rv, (c != TO), (c == TO)); end
        end
        tick();
        s0_rd = 0;
        @(negedge clk);
        checks++; if (terr !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL to_err: got terr=%b grant=%b expected 1 00", terr, grant); end
        tick();
        s1_wr = 1; s1_addr = 32'h500; s1_wdata = 32'h77; s0_rd = 1;
        exp_q0.push_back(32'hDEADBEEF);
        @(negedge clk);
        checks++; if (s1_wait !== 1'b0 || s0_wait !== 1'b0 || b_wr !== 1'b0 || b_rd !== 1'b0) begin errors++; $display("FAIL to_err_serve: got w1=%b w0=%b wr=%b rd=%b expected 0 0 0 0", s1_wait, s0_wait, b_wr, b_rd); end
        tick();
        s1_wr = 0; s0_rd = 0;
        tick();
        tclr = 1;
        @(negedge clk);
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL to_before_clr: got %b expected 1", terr); end
        tick();
        tclr = 0; s0_wr = 1; s0_addr = 32'h600; b_wait = 1;
        @(negedge clk);
        checks++; if (terr !== 1'b0 || s0_wait !== 1'b1 || b_wr !== 1'b0) begin errors++; $display("FAIL to_cleared: got terr=%b wait=%b wr=%b expected 0 1 0", terr, s0_wait, b_wr); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b01 || b_wr !== 1'b1 || b_addr !== 32'h600) begin errors++; $display("FAIL to_resume: got grant=%b wr=%b addr=%h expected 01 1 600", grant, b_wr, b_addr); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        s1_rd = 1; s1_addr = 32'h700; b_wait = 1;
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b10 || b_rd !== 1'b1) begin errors++; $display("FAIL rst_pre: got grant=%b rd=%b expected 10 1", grant, b_rd); end
        tick();
        rst = 1;
        #1;
        checks++; if (grant !== 2'b00 || b_rd !== 1'b0 || b_wr !== 1'b0 || terr !== 1'b0) begin errors++; $display("FAIL rst_async: got grant=%b rd=%b wr=%b terr=%b expected 00 0 0 0", grant, b_rd, b_wr, terr); end
        checks++; if (s1_wait !== 1'b1) begin errors++; $display("FAIL rst_wait: got %b expected 1", s1_wait); end
        s1_rd = 0;
        tick();
        rst = 0;
        s0_wr = 1; s0_addr = 32'h800; s1_wr = 1; s1_addr = 32'h900;
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b01 || b_addr !== 32'h800) begin errors++; $display("FAIL rst_tie: got grant=%b addr=%h expected 01 800", grant, b_addr); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_write();
        test_both_read();
        test_read_early();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        checks++; if (exp_q0.size() !== 0) begin errors++; $display("FAIL s0_queue_drain: got %0d pending expected 0", exp_q0.size()); end
        checks++; if (exp_q1.size() !== 0) begin errors++; $display("FAIL s1_queue_drain: got %0d pending expected 0", exp_q1.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
